// File: rtl/arf_sched_ctrl.sv
// ----------------------------------------------------------------------------
// arf_sched_ctrl
//   Runs a host-loaded, in-order add/mul schedule (ARF-class DFG) against a
//   32-entry register file. One shared single-cycle adder and one shared
//   fully pipelined multiplier. Issues at most one op per cycle and stalls
//   on RAW/WAW hazards tracked by a per-register pending scoreboard.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_we/addr/data    schedule memory write (IDLE only)
//                       word: [15]=op (0 add, 1 mul), [14:10]=srcA,
//                             [9:5]=srcB, [4:0]=dst
//   prog_len            instruction count, sampled on start
//   rf_we/waddr/wdata   host register-file write (IDLE only)
//   rf_raddr/rf_rdata   combinational register-file read
//   start               begin execution (IDLE only)
//   busy                high while RUN or DRAIN
//   done                one-cycle completion pulse
//   cycle_cnt           busy cycles in the last run
//   stall_cnt           hazard-stall cycles in the last run
// ----------------------------------------------------------------------------
module arf_sched_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned MAX_INSTR = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [4:0]       cfg_addr,
  input  logic [15:0]      cfg_data,
  input  logic [5:0]       prog_len,
  input  logic             rf_we,
  input  logic [4:0]       rf_waddr,
  input  logic [WIDTH-1:0] rf_wdata,
  input  logic [4:0]       rf_raddr,
  output logic [WIDTH-1:0] rf_rdata,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      cycle_cnt,
  output logic [15:0]      stall_cnt
);

  localparam int unsigned NREG   = 32;
  localparam int unsigned STAGES = MUL_LAT - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic [15:0]        cycle_q;
  logic [15:0]        stall_q;
  logic [5:0]         pc_q;
  logic [5:0]         len_q;

  logic [15:0]        imem_q [NREG];
  logic [WIDTH-1:0]   rf_q   [NREG];
  logic [NREG-1:0]    pend_q, pend_d;
  logic [STAGES-1:0]  mvld_q, mvld_d;
  logic [4:0]         mdst_q [STAGES];
  logic [WIDTH-1:0]   mres_q [STAGES];

  logic [15:0]        instr_c;
  logic               op_c;
  logic [4:0]         sa_c, sb_c, dst_c;
  logic [WIDTH-1:0]   opa_c, opb_c;
  logic [WIDTH-1:0]   add_res_c, mul_res_c;
  logic               hazard_c, issue_c, last_c, inflight_c;
  logic               mul_wb_c;
  logic [4:0]         wb_dst_c;
  logic [WIDTH-1:0]   wb_res_c;
  logic [5:0]         start_len_c;
  logic               idle_c;

  // Instruction decode and combinational operand read at pc
  always_comb begin
    instr_c   = imem_q[pc_q[4:0]];
    op_c      = instr_c[15];
    sa_c      = instr_c[14:10];
    sb_c      = instr_c[9:5];
    dst_c     = instr_c[4:0];
    opa_c     = rf_q[sa_c];
    opb_c     = rf_q[sb_c];
    // low WIDTH bits of the product only depend on the low WIDTH bits
    add_res_c = opa_c + opb_c;
    mul_res_c = opa_c * opb_c;
  end

  // Issue control: stall while any operand or the destination is pending
  always_comb begin
    idle_c      = (state_q == S_IDLE);
    hazard_c    = pend_q[sa_c] | pend_q[sb_c] | pend_q[dst_c];
    issue_c     = (state_q == S_RUN) && !hazard_c;
    last_c      = (pc_q == len_q - 6'd1);
    mul_wb_c    = mvld_q[STAGES-1];
    wb_dst_c    = mdst_q[STAGES-1];
    wb_res_c    = mres_q[STAGES-1];
    start_len_c = (32'(prog_len) > MAX_INSTR) ? 6'(MAX_INSTR) : prog_len;
  end

  // Next multiplier valid pattern; empty means nothing is left in flight
  always_comb begin
    mvld_d    = '0;
    mvld_d[0] = issue_c & op_c;
    for (int unsigned i = 1; i < STAGES; i++) begin
      mvld_d[i] = mvld_q[i-1];
    end
    inflight_c = |mvld_d;
  end

  // Scoreboard: set on mul issue, cleared on mul writeback
  always_comb begin
    pend_d = pend_q;
    if (mul_wb_c) begin
      pend_d[wb_dst_c] = 1'b0;
    end
    if (issue_c && op_c) begin
      pend_d[dst_c] = 1'b1;
    end
  end

  // Sequencer FSM with registered status outputs and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cycle_q <= '0;
      stall_q <= '0;
      pc_q    <= '0;
      len_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q    <= '0;
            cycle_q <= '0;
            stall_q <= '0;
            len_q   <= start_len_c;
            if (start_len_c == 6'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cycle_q <= cycle_q + 16'd1;
          if (!issue_c) begin
            stall_q <= stall_q + 16'd1;
          end else begin
            pc_q <= pc_q + 6'd1;
            if (last_c) begin
              if (inflight_c) begin
                state_q <= S_DRAIN;
              end else begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          cycle_q <= cycle_q + 16'd1;
          if (!inflight_c) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Scoreboard and multiplier valid bits; reset discards in-flight results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      mvld_q <= '0;
    end else begin
      pend_q <= pend_d;
      mvld_q <= mvld_d;
    end
  end

  // Multiplier pipeline payload, qualified by mvld_q
  always_ff @(posedge clk) begin
    mdst_q[0] <= dst_c;
    mres_q[0] <= mul_res_c;
    for (int unsigned i = 1; i < STAGES; i++) begin
      mdst_q[i] <= mdst_q[i-1];
      mres_q[i] <= mres_q[i-1];
    end
  end

  // Register file: adder port (shared with host in IDLE) and multiplier port
  always_ff @(posedge clk) begin
    if (rf_we && idle_c) begin
      rf_q[rf_waddr] <= rf_wdata;
    end else if (issue_c && !op_c) begin
      rf_q[dst_c] <= add_res_c;
    end
    if (mul_wb_c) begin
      rf_q[wb_dst_c] <= wb_res_c;
    end
  end

  // Schedule memory, host-writable only in IDLE
  always_ff @(posedge clk) begin
    if (cfg_we && idle_c && (32'(cfg_addr) < MAX_INSTR)) begin
      imem_q[cfg_addr] <= cfg_data;
    end
  end

  assign rf_rdata  = rf_q[rf_raddr];
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_arf_sched_ctrl.sv
module tb_arf_sched_ctrl;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned MUL_LAT = 3;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [4:0]       cfg_addr;
  logic [15:0]      cfg_data;
  logic [5:0]       prog_len;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [4:0]       rf_raddr;
  logic [WIDTH-1:0] rf_rdata;
  logic             start;
  logic             busy;
  logic             done;
  logic [15:0]      cycle_cnt;
  logic [15:0]      stall_cnt;

  arf_sched_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .MAX_INSTR(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .prog_len(prog_len),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .start(start), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc(input logic op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [4:0] d);
    return {op, a, b, d};
  endfunction

  task automatic wr_rf(input logic [4:0] a, input logic [15:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic wr_cfg(input logic [4:0] a, input logic [15:0] w);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = w;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd_rf(input logic [4:0] a, output logic [15:0] v);
    rf_raddr = a;
    #1;
    v = rf_rdata;
  endtask

  // Start a run and wait (bounded) for done; checks done is a single pulse
  task automatic run_prog(input string name, input logic [5:0] len,
                          output int done_k, output int last_busy);
    prog_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_k = -1;
    last_busy = -1;
    for (int k = 0; k < 500; k++) begin
      if (busy) last_busy = k;
      if (done) begin
        done_k = k;
        break;
      end
      tick();
    end
    chk({name, "_done_seen"}, 32'(done_k >= 0), 32'd1);
    if (done_k >= 0) begin
      tick();
      chk({name, "_done_width"}, 32'(done), 32'd0);
    end
  endtask

  // Sequential reference interpreter of a program over a register array
  function automatic void model_exec(inout logic [15:0] m [32], input logic [15:0] w);
    logic [15:0] a, b;
    a = m[w[14:10]];
    b = m[w[9:5]];
    m[w[4:0]] = w[15] ? 16'(a * b) : 16'(a + b);
  endfunction

  typedef struct {
    logic        op;
    logic [4:0]  sa, sb, dst;
    logic [15:0] a, b, exp;
    int          cyc;
  } vec_t;

  vec_t        vt [10];
  logic [15:0] v;
  logic [15:0] arf [28];
  logic [15:0] mdl [32];
  int          dk, lb;

  initial begin
    // Single-instruction vectors: RF0=a, RF1=b, result read from dst
    vt[0] = '{1'b0, 5'd0, 5'd1, 5'd2, 16'd3,    16'd5,    16'd8,    1};
    vt[1] = '{1'b1, 5'd0, 5'd1, 5'd2, 16'd3,    16'd5,    16'd15,   3};
    vt[2] = '{1'b0, 5'd0, 5'd1, 5'd2, 16'hFFFF, 16'h0002, 16'h0001, 1};
    vt[3] = '{1'b1, 5'd0, 5'd1, 5'd3, 16'h0100, 16'h0100, 16'h0000, 3};
    vt[4] = '{1'b1, 5'd0, 5'd1, 5'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 3};
    vt[5] = '{1'b0, 5'd0, 5'd1, 5'd2, 16'h8000, 16'h8000, 16'h0000, 1};
    vt[6] = '{1'b1, 5'd0, 5'd1, 5'd2, 16'h1234, 16'h0010, 16'h2340, 3};
    vt[7] = '{1'b0, 5'd0, 5'd1, 5'd2, 16'h7FFF, 16'h0001, 16'h8000, 1};
    vt[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 16'd7,    16'd1,    16'd14,   1};
    vt[9] = '{1'b1, 5'd1, 5'd0, 5'd1, 16'd3,    16'd9,    16'd27,   3};

    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    prog_len = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; rf_raddr = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      wr_rf(5'd0, vt[i].a);
      wr_rf(5'd1, vt[i].b);
      wr_cfg(5'd0, enc(vt[i].op, vt[i].sa, vt[i].sb, vt[i].dst));
      run_prog($sformatf("vec%0d", i), 6'd1, dk, lb);
      rd_rf(vt[i].dst, v);
      chk($sformatf("vec%0d_result", i), 32'(v), 32'(vt[i].exp));
      chk($sformatf("vec%0d_cycle_cnt", i), 32'(cycle_cnt), 32'(vt[i].cyc));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'd0);
      chk($sformatf("vec%0d_done_after_busy", i), 32'(dk), 32'(lb + 1));
    end

    // RAW chain through the multiplier
    wr_rf(5'd0, 16'd3);
    wr_rf(5'd1, 16'd5);
    wr_cfg(5'd0, enc(1'b1, 5'd0, 5'd1, 5'd2));
    wr_cfg(5'd1, enc(1'b0, 5'd2, 5'd0, 5'd3));
    run_prog("raw", 6'd2, dk, lb);
    rd_rf(5'd3, v); chk("raw_r3", 32'(v), 32'd18);
    rd_rf(5'd2, v); chk("raw_r2", 32'(v), 32'd15);
    chk("raw_cycle_cnt", 32'(cycle_cnt), 32'd4);
    chk("raw_stall_cnt", 32'(stall_cnt), 32'd2);

    // Back-to-back independent muls
    wr_rf(5'd0, 16'd2);   wr_rf(5'd1, 16'd3);
    wr_rf(5'd3, 16'd4);   wr_rf(5'd4, 16'd5);
    wr_rf(5'd6, 16'd6);   wr_rf(5'd7, 16'd7);
    wr_rf(5'd9, 16'h0100); wr_rf(5'd10, 16'h0101);
    wr_cfg(5'd0, enc(1'b1, 5'd0, 5'd1, 5'd2));
    wr_cfg(5'd1, enc(1'b1, 5'd3, 5'd4, 5'd5));
    wr_cfg(5'd2, enc(1'b1, 5'd6, 5'd7, 5'd8));
    wr_cfg(5'd3, enc(1'b1, 5'd9, 5'd10, 5'd11));
    run_prog("b2b", 6'd4, dk, lb);
    chk("b2b_cycle_cnt", 32'(cycle_cnt), 32'd6);
    chk("b2b_stall_cnt", 32'(stall_cnt), 32'd0);
    rd_rf(5'd2, v);  chk("b2b_r2", 32'(v), 32'd6);
    rd_rf(5'd5, v);  chk("b2b_r5", 32'(v), 32'd20);
    rd_rf(5'd8, v);  chk("b2b_r8", 32'(v), 32'd42);
    rd_rf(5'd11, v); chk("b2b_r11", 32'(v), 32'h0100);

    // Empty program
    run_prog("len0", 6'd0, dk, lb);
    chk("len0_done_k", 32'(dk), 32'd0);
    chk("len0_never_busy", 32'(lb), 32'hFFFF_FFFF);
    chk("len0_cycle_cnt", 32'(cycle_cnt), 32'd0);

    // Host writes and start while busy must be ignored
    wr_rf(5'd0, 16'd3);
    wr_rf(5'd1, 16'd5);
    wr_cfg(5'd0, enc(1'b1, 5'd0, 5'd1, 5'd2));
    wr_cfg(5'd1, enc(1'b1, 5'd2, 5'd2, 5'd3));
    prog_len = 6'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("busywr_busy", 32'(busy), 32'd1);
    rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 16'hDEAD;
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = enc(1'b0, 5'd0, 5'd1, 5'd3);
    start = 1'b1;
    tick();
    rf_we = 1'b0; cfg_we = 1'b0; start = 1'b0;
    dk = -1;
    for (int k = 0; k < 500; k++) begin
      if (done) begin dk = k; break; end
      tick();
    end
    chk("busywr_done_seen", 32'(dk >= 0), 32'd1);
    chk("busywr_cycle_cnt", 32'(cycle_cnt), 32'd6);
    chk("busywr_stall_cnt", 32'(stall_cnt), 32'd2);
    tick();
    rd_rf(5'd0, v); chk("busywr_r0", 32'(v), 32'd3);
    rd_rf(5'd2, v); chk("busywr_r2", 32'(v), 32'd15);
    rd_rf(5'd3, v); chk("busywr_r3", 32'(v), 32'd225);
    run_prog("busywr_rerun", 6'd2, dk, lb);
    chk("busywr_rerun_cycle_cnt", 32'(cycle_cnt), 32'd6);
    rd_rf(5'd3, v); chk("busywr_rerun_r3", 32'(v), 32'd225);

    // Full ARF schedule: 16 mul, 12 add, random operands
    arf[0]  = enc(1'b1, 5'd0, 5'd8, 5'd16);   arf[1]  = enc(1'b1, 5'd1, 5'd9, 5'd17);
    arf[2]  = enc(1'b1, 5'd0, 5'd9, 5'd18);   arf[3]  = enc(1'b1, 5'd1, 5'd8, 5'd19);
    arf[4]  = enc(1'b0, 5'd16, 5'd17, 5'd20); arf[5]  = enc(1'b0, 5'd18, 5'd19, 5'd21);
    arf[6]  = enc(1'b1, 5'd2, 5'd10, 5'd22);  arf[7]  = enc(1'b1, 5'd3, 5'd11, 5'd23);
    arf[8]  = enc(1'b1, 5'd2, 5'd11, 5'd24);  arf[9]  = enc(1'b1, 5'd3, 5'd10, 5'd25);
    arf[10] = enc(1'b0, 5'd22, 5'd23, 5'd26); arf[11] = enc(1'b0, 5'd24, 5'd25, 5'd27);
    arf[12] = enc(1'b1, 5'd4, 5'd12, 5'd16);  arf[13] = enc(1'b1, 5'd5, 5'd13, 5'd17);
    arf[14] = enc(1'b1, 5'd4, 5'd13, 5'd18);  arf[15] = enc(1'b1, 5'd5, 5'd12, 5'd19);
    arf[16] = enc(1'b0, 5'd16, 5'd17, 5'd22); arf[17] = enc(1'b0, 5'd18, 5'd19, 5'd23);
    arf[18] = enc(1'b1, 5'd6, 5'd14, 5'd24);  arf[19] = enc(1'b1, 5'd7, 5'd15, 5'd25);
    arf[20] = enc(1'b1, 5'd6, 5'd15, 5'd16);  arf[21] = enc(1'b1, 5'd7, 5'd14, 5'd17);
    arf[22] = enc(1'b0, 5'd24, 5'd25, 5'd18); arf[23] = enc(1'b0, 5'd16, 5'd17, 5'd19);
    arf[24] = enc(1'b0, 5'd20, 5'd26, 5'd28); arf[25] = enc(1'b0, 5'd22, 5'd18, 5'd29);
    arf[26] = enc(1'b0, 5'd28, 5'd21, 5'd30); arf[27] = enc(1'b0, 5'd29, 5'd27, 5'd31);
    for (int r = 0; r < 32; r++) mdl[r] = '0;
    for (int r = 0; r < 16; r++) begin
      mdl[r] = 16'($urandom);
      wr_rf(5'(r), mdl[r]);
    end
    for (int i = 0; i < 28; i++) begin
      wr_cfg(5'(i), arf[i]);
      model_exec(mdl, arf[i]);
    end
    run_prog("arf", 6'd28, dk, lb);
    for (int r = 16; r < 32; r++) begin
      rd_rf(5'(r), v);
      chk($sformatf("arf_r%0d", r), 32'(v), 32'(mdl[r]));
    end

    // Reset during DRAIN: in-flight muls must never land
    wr_rf(5'd0, 16'd3);
    wr_rf(5'd1, 16'd5);
    wr_rf(5'd4, 16'hAAAA);
    wr_rf(5'd5, 16'h5555);
    wr_cfg(5'd0, enc(1'b1, 5'd0, 5'd1, 5'd4));
    wr_cfg(5'd1, enc(1'b1, 5'd0, 5'd0, 5'd5));
    prog_len = 6'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rstdrain_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstdrain_busy", 32'(busy), 32'd0);
    chk("rstdrain_done", 32'(done), 32'd0);
    chk("rstdrain_cycle_cnt", 32'(cycle_cnt), 32'd0);
    tick();
    rst = 1'b0;
    dk = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy) dk = 1;
      tick();
    end
    chk("rstdrain_no_done", 32'(dk), 32'd0);
    rd_rf(5'd4, v); chk("rstdrain_r4", 32'(v), 32'hAAAA);
    rd_rf(5'd5, v); chk("rstdrain_r5", 32'(v), 32'h5555);

    // Scoreboard must be clear after reset: dependent add issues at once
    wr_cfg(5'd0, enc(1'b0, 5'd4, 5'd5, 5'd6));
    run_prog("post_rst", 6'd1, dk, lb);
    rd_rf(5'd6, v); chk("post_rst_r6", 32'(v), 32'hFFFF);
    chk("post_rst_cycle_cnt", 32'(cycle_cnt), 32'd1);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
